// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: IR field positions, PC step,
// fetch state encoding and a word-alignment helper.
package cpu_pkg;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int TGT_HI   = 25;
  localparam int TGT_LO   = 0;

  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

  // Instruction addresses are always word aligned; drop the byte offset.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_reg_if.sv
// Instruction-memory read bus between the fetch stage (master) and memory (slave).
interface instr_fetch_reg_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ready);
  modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ready);
endinterface

// File: rtl/fetch_watchdog.sv
// Cycle counter guarding a memory fetch; flags the cycle in which the
// FETCH_TIMEOUT-th consecutive stalled cycle is being counted.
module fetch_watchdog #(
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST_CNT = 8'(FETCH_TIMEOUT - 1);

  logic [7:0] count_r;

  // Count enabled cycles, restarting whenever the fetch is not active.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 8'd0;
    end else if (clear) begin
      count_r <= 8'd0;
    end else if (enable) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && (count_r == LAST_CNT);

endmodule

// File: rtl/instr_fetch_reg.sv
// Instruction fetch stage and instruction register: fetches one word per
// request, advances the PC, buffers mid-fetch PC writes and splits the IR.
module instr_fetch_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_RESET      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_start,
  input  logic                pc_we,
  input  logic [31:0]         pc_wdata,
  instr_fetch_reg_if.master   mem,
  output logic [31:0]         pc,
  output logic [31:0]         ir,
  output logic                ir_valid,
  output logic                fetch_done,
  output logic                fetch_err,
  output logic [5:0]          opcode,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          rd,
  output logic [4:0]          shamt,
  output logic [5:0]          funct,
  output logic [15:0]         imm16,
  output logic [25:0]         target26
);

  fetch_state_e state_r, state_nxt_s;

  logic [31:0] pc_r, pc_nxt_s;
  logic [31:0] ir_r, ir_nxt_s;
  logic [31:0] addr_r, addr_nxt_s;
  logic [31:0] pend_pc_r, pend_pc_nxt_s;
  logic        ir_valid_r, ir_valid_nxt_s;
  logic        req_r, req_nxt_s;
  logic        done_r, done_nxt_s;
  logic        err_r, err_nxt_s;
  logic        pend_valid_r, pend_valid_nxt_s;
  logic [31:0] wdata_al_s;
  logic        wd_clear_s, wd_enable_s, wd_expired_s;

  assign wdata_al_s  = align_word(pc_wdata);
  assign wd_clear_s  = (state_r == IDLE);
  assign wd_enable_s = (state_r == FETCH) && !mem.mem_ready;

  fetch_watchdog #(.FETCH_TIMEOUT(FETCH_TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear_s),
    .enable  (wd_enable_s),
    .expired (wd_expired_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: start on request, leave FETCH on ready or timeout.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (fetch_start && !err_r) state_nxt_s = FETCH;
        else                       state_nxt_s = IDLE;
      end
      FETCH: begin
        if (mem.mem_ready || wd_expired_s) state_nxt_s = IDLE;
        else                               state_nxt_s = FETCH;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output/datapath next values; ready beats timeout, a same-cycle pc_we beats the buffer.
  always_comb begin
    pc_nxt_s         = pc_r;
    ir_nxt_s         = ir_r;
    ir_valid_nxt_s   = ir_valid_r;
    req_nxt_s        = req_r;
    addr_nxt_s       = addr_r;
    done_nxt_s       = 1'b0;
    err_nxt_s        = err_r;
    pend_valid_nxt_s = pend_valid_r;
    pend_pc_nxt_s    = pend_pc_r;
    case (state_r)
      IDLE: begin
        if (pc_we) pc_nxt_s = wdata_al_s;
        else       pc_nxt_s = pc_r;
        if (fetch_start && !err_r) begin
          req_nxt_s      = 1'b1;
          addr_nxt_s     = pc_we ? wdata_al_s : pc_r;
          ir_valid_nxt_s = 1'b0;
        end else begin
          req_nxt_s = 1'b0;
        end
      end
      FETCH: begin
        if (mem.mem_ready) begin
          ir_nxt_s         = mem.mem_rdata;
          ir_valid_nxt_s   = 1'b1;
          done_nxt_s       = 1'b1;
          req_nxt_s        = 1'b0;
          pend_valid_nxt_s = 1'b0;
          if (pc_we)             pc_nxt_s = wdata_al_s;
          else if (pend_valid_r) pc_nxt_s = pend_pc_r;
          else                   pc_nxt_s = addr_r + PC_INC;
        end else if (wd_expired_s) begin
          err_nxt_s        = 1'b1;
          req_nxt_s        = 1'b0;
          pend_valid_nxt_s = 1'b0;
          if (pc_we)             pc_nxt_s = wdata_al_s;
          else if (pend_valid_r) pc_nxt_s = pend_pc_r;
          else                   pc_nxt_s = pc_r;
        end else if (pc_we) begin
          pend_valid_nxt_s = 1'b1;
          pend_pc_nxt_s    = wdata_al_s;
        end else begin
          pend_valid_nxt_s = pend_valid_r;
        end
      end
      default: begin
        req_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r         <= PC_RESET;
      ir_r         <= 32'h0000_0000;
      ir_valid_r   <= 1'b0;
      req_r        <= 1'b0;
      addr_r       <= 32'h0000_0000;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      pend_valid_r <= 1'b0;
      pend_pc_r    <= 32'h0000_0000;
    end else begin
      pc_r         <= pc_nxt_s;
      ir_r         <= ir_nxt_s;
      ir_valid_r   <= ir_valid_nxt_s;
      req_r        <= req_nxt_s;
      addr_r       <= addr_nxt_s;
      done_r       <= done_nxt_s;
      err_r        <= err_nxt_s;
      pend_valid_r <= pend_valid_nxt_s;
      pend_pc_r    <= pend_pc_nxt_s;
    end
  end

  assign mem.mem_req  = req_r;
  assign mem.mem_addr = addr_r;
  assign pc           = pc_r;
  assign ir           = ir_r;
  assign ir_valid     = ir_valid_r;
  assign fetch_done   = done_r;
  assign fetch_err    = err_r;

  assign opcode   = ir_r[OPC_HI:OPC_LO];
  assign rs       = ir_r[RS_HI:RS_LO];
  assign rt       = ir_r[RT_HI:RT_LO];
  assign rd       = ir_r[RD_HI:RD_LO];
  assign shamt    = ir_r[SHAMT_HI:SHAMT_LO];
  assign funct    = ir_r[FUNCT_HI:FUNCT_LO];
  assign imm16    = ir_r[IMM_HI:IMM_LO];
  assign target26 = ir_r[TGT_HI:TGT_LO];

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Scoreboard bench for instr_fetch_reg: directed fetches push expected IR/PC,
// a monitor checks each fetch_done, a memory responder checks addresses.
module tb_instr_fetch_reg;

  logic        clk;
  logic        reset;
  logic        fetch_start;
  logic        pc_we;
  logic [31:0] pc_wdata;
  logic [31:0] pc, ir;
  logic        ir_valid, fetch_done, fetch_err;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] target26;

  instr_fetch_reg_if bus ();

  instr_fetch_reg #(.PC_RESET(32'h0000_0000), .FETCH_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc_we(pc_we),
    .pc_wdata(pc_wdata), .mem(bus.master), .pc(pc), .ir(ir),
    .ir_valid(ir_valid), .fetch_done(fetch_done), .fetch_err(fetch_err),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm16(imm16), .target26(target26)
  );

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          total_cnt = 0;
  int          fail_cnt  = 0;
  int          resp_delay = 0;
  bit          resp_on = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h3C01_1234;
      32'h0000_0200: return 32'h2402_00AB;
      32'h0000_0010: return 32'h8C22_0010;
      32'hFFFF_FFFC: return 32'hAC43_FFF8;
      default:       return a ^ 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input logic [31:0] addr, input logic [31:0] pc_after);
    exp_t e;
    e.ir = mem_word(addr);
    e.pc = pc_after;
    addr_q.push_back(addr);
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.mem_req) && n < 100) begin
      tick();
      n++;
    end
    chk(name, 32'(n < 100), 32'd1);
  endtask

  // Memory responder: checks each new request address, answers after resp_delay.
  initial begin
    int  wait_cnt = 0;
    bit  in_req = 1'b0;
    logic [31:0] ea;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0000_0000;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b0;
      if (bus.mem_req === 1'b1) begin
        if (!in_req) begin
          in_req = 1'b1;
          wait_cnt = 0;
          chk("req_expected", 32'(addr_q.size() != 0), 32'd1);
          if (addr_q.size() != 0) begin
            ea = addr_q.pop_front();
            chk("mem_addr", bus.mem_addr, ea);
          end
        end
        if (resp_on) begin
          if (wait_cnt == resp_delay) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = mem_word(bus.mem_addr);
          end else begin
            wait_cnt++;
          end
        end
      end else begin
        in_req = 1'b0;
      end
    end
  end

  // Monitor: on each fetch_done pop the scoreboard and compare IR, PC and fields.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (fetch_done === 1'b1) begin
        chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("ir", ir, e.ir);
          chk("pc_after", pc, e.pc);
          chk("ir_valid", 32'(ir_valid), 32'd1);
          chk("opcode", 32'(opcode), 32'(e.ir[31:26]));
          chk("rs", 32'(rs), 32'(e.ir[25:21]));
          chk("rt", 32'(rt), 32'(e.ir[20:16]));
          chk("rd", 32'(rd), 32'(e.ir[15:11]));
          chk("shamt", 32'(shamt), 32'(e.ir[10:6]));
          chk("funct", 32'(funct), 32'(e.ir[5:0]));
          chk("imm16", 32'(imm16), 32'(e.ir[15:0]));
          chk("target26", 32'(target26), 32'(e.ir[25:0]));
        end
        @(negedge clk);
        chk("done_pulse", 32'(fetch_done), 32'd0);
      end
    end
  end

  // Global guard so the run can never hang.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  // Directed stimulus.
  initial begin
    int n;
    reset = 1'b1; fetch_start = 1'b0; pc_we = 1'b0; pc_wdata = 32'h0;
    tick(); tick();
    @(negedge clk);
    chk("rst_pc", pc, 32'h0000_0000);
    chk("rst_ir", ir, 32'h0000_0000);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0000_0000);
    chk("rst_done", 32'(fetch_done), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    tick();
    reset = 1'b0;

    // Basic fetch of lui-type word at 0, ready two cycles after request.
    resp_delay = 2;
    expect_fetch(32'h0000_0000, 32'h0000_0004);
    fetch_start = 1'b1; tick(); fetch_start = 1'b0;
    wait_done("t1_wait");
    @(negedge clk);
    chk("t1_opcode", 32'(opcode), 32'h0000_000F);
    chk("t1_rt", 32'(rt), 32'd1);
    chk("t1_imm16", 32'(imm16), 32'h0000_1234);

    // Idle PC write with alignment, then write-through fetch.
    tick();
    pc_we = 1'b1; pc_wdata = 32'h0000_0103; tick(); pc_we = 1'b0;
    @(negedge clk);
    chk("t2_pc_align", pc, 32'h0000_0100);
    tick();
    resp_delay = 0;
    expect_fetch(32'h0000_0200, 32'h0000_0204);
    fetch_start = 1'b1; pc_we = 1'b1; pc_wdata = 32'h0000_0200;
    tick(); fetch_start = 1'b0; pc_we = 1'b0;
    wait_done("t2_wait");

    // Mid-fetch branch writes are buffered; last one wins.
    pc_we = 1'b1; pc_wdata = 32'h0000_0010; tick(); pc_we = 1'b0;
    resp_delay = 4;
    expect_fetch(32'h0000_0010, 32'h0000_0040);
    fetch_start = 1'b1; tick(); fetch_start = 1'b0;
    pc_we = 1'b1; pc_wdata = 32'h0000_0080; tick();
    pc_wdata = 32'h0000_0040; tick(); pc_we = 1'b0;
    @(negedge clk);
    chk("t3_pc_held", pc, 32'h0000_0010);
    wait_done("t3_wait");

    // Wrap at top of address space.
    pc_we = 1'b1; pc_wdata = 32'hFFFF_FFFC; tick(); pc_we = 1'b0;
    resp_delay = 1;
    expect_fetch(32'hFFFF_FFFC, 32'h0000_0000);
    fetch_start = 1'b1; tick(); fetch_start = 1'b0;
    wait_done("t5_wait");

    // Timeout: no ready, request must last exactly 8 cycles.
    resp_on = 1'b0;
    addr_q.push_back(32'h0000_0000);
    fetch_start = 1'b1; tick(); fetch_start = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) n++;
    end
    chk("t4_req_cycles", 32'(n), 32'd8);
    chk("t4_err", 32'(fetch_err), 32'd1);
    chk("t4_ir_valid", 32'(ir_valid), 32'd0);
    chk("t4_ir_kept", ir, 32'hAC43_FFF8);
    chk("t4_pc_kept", pc, 32'h0000_0000);
    tick();
    fetch_start = 1'b1; tick(); fetch_start = 1'b0; tick();
    @(negedge clk);
    chk("t4_start_ignored", 32'(bus.mem_req), 32'd0);
    reset = 1'b1; tick(); reset = 1'b0;
    @(negedge clk);
    chk("t4_err_cleared", 32'(fetch_err), 32'd0);
    chk("t4_ir_cleared", ir, 32'h0000_0000);
    tick();

    // Reset mid-fetch, with a pending PC write that must be discarded.
    resp_on = 1'b1; resp_delay = 5;
    addr_q.push_back(32'h0000_0000);
    fetch_start = 1'b1; tick(); fetch_start = 1'b0;
    pc_we = 1'b1; pc_wdata = 32'h0000_0300; tick(); pc_we = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    @(negedge clk);
    chk("t6_req_dropped", 32'(bus.mem_req), 32'd0);
    chk("t6_pc_reset", pc, 32'h0000_0000);
    chk("t6_ir_reset", ir, 32'h0000_0000);
    tick();
    resp_delay = 0;
    expect_fetch(32'h0000_0000, 32'h0000_0004);
    fetch_start = 1'b1; tick(); fetch_start = 1'b0;
    wait_done("t6_wait");
    tick(); tick();

    $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
    $finish;
  end

endmodule
